// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S constants and stereo frame type
package i2s_pkg;
  localparam int I2S_WORD_W = 32;
  localparam int I2S_DATA_W = 24;
  localparam logic LR_LEFT = 1'b0;
  localparam logic LR_RIGHT = 1'b1;
  typedef struct packed {
    logic [I2S_WORD_W-1:0] left;
    logic [I2S_WORD_W-1:0] right;
  } stereo_frame_t;
endpackage

// File: rtl/i2s_rx_if.sv
// i2s_rx_if: serial inputs and stereo frame valid/ready bus of the I2S receiver
interface i2s_rx_if #(parameter int OUT_W = 32) ();
  logic lr_clk;
  logic sd;
  logic frame_ready;
  logic frame_valid;
  logic [OUT_W-1:0] left_data;
  logic [OUT_W-1:0] right_data;
  logic slot_err;
  logic overrun;
  modport master (
    input lr_clk, sd, frame_ready,
    output frame_valid, left_data, right_data, slot_err, overrun
  );
  modport slave (
    output lr_clk, sd, frame_ready,
    input frame_valid, left_data, right_data, slot_err, overrun
  );
endinterface

// File: rtl/i2s_slot_deser.sv
// i2s_slot_deser: tracks word select, counts slot bits and shifts in MSB-first data
module i2s_slot_deser #(
  parameter int WORD_W = 32,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lr_clk,
  input  logic              sd,
  output logic              slot_done,
  output logic              len_ok,
  output logic              chan,
  output logic [DATA_W-1:0] word
);
  localparam int CW = $clog2(WORD_W + 2);
  localparam logic [CW-1:0] LEN_C = CW'(WORD_W - 1);
  localparam logic [CW-1:0] MAX_C = CW'(WORD_W + 1);
  localparam logic [CW-1:0] DW_C = CW'(DATA_W);
  logic              lr_q;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  assign slot_done = lr_clk != lr_q;
  assign len_ok = bit_cnt == LEN_C;
  assign chan = lr_q;
  // the slot's final bit arrives on the transition edge and only counts as data when every slot bit is data
  assign word = (DATA_W == WORD_W) ? {shift[DATA_W-2:0], sd} : shift;
  // word-select tracking, saturating bit counter and data shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_q <= 1'b0;
      bit_cnt <= '0;
      shift <= '0;
    end else begin
      lr_q <= lr_clk;
      if (slot_done) begin
        bit_cnt <= '0;
        shift <= '0;
      end else begin
        if (bit_cnt < DW_C) shift <= {shift[DATA_W-2:0], sd};
        if (bit_cnt != MAX_C) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver assembling left/right slots into stereo frames; I2S_RX_SIGN_EXT_EN sign-extends samples
module i2s_rx import i2s_pkg::*; #(
  parameter int WORD_W = I2S_WORD_W,
  parameter int DATA_W = I2S_DATA_W,
  parameter int OUT_W = 32
) (
  input logic      clk,
  input logic      rst,
  i2s_rx_if.master bus
);
  logic              slot_done, len_ok, chan, synced, left_pend, frame_done, slot_good;
  logic [DATA_W-1:0] word, left_hold;
  i2s_slot_deser #(.WORD_W(WORD_W), .DATA_W(DATA_W)) u_deser (
    .clk(clk),
    .rst(rst),
    .lr_clk(bus.lr_clk),
    .sd(bus.sd),
    .slot_done(slot_done),
    .len_ok(len_ok),
    .chan(chan),
    .word(word)
  );
  function automatic logic [OUT_W-1:0] fmt(input logic [DATA_W-1:0] w);
`ifdef I2S_RX_SIGN_EXT_EN
    return OUT_W'($signed(w));
`else
    return OUT_W'(w);
`endif
  endfunction
  assign slot_good = slot_done & synced & len_ok;
  assign frame_done = slot_good & (chan == LR_RIGHT) & left_pend;
  // sync, left-word pairing, output register and valid/ready handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      synced <= 1'b0;
      left_pend <= 1'b0;
      left_hold <= '0;
      bus.frame_valid <= 1'b0;
      bus.left_data <= '0;
      bus.right_data <= '0;
      bus.slot_err <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.slot_err <= slot_done & synced & ~len_ok;
      if (slot_done) synced <= 1'b1;
      if (slot_done & synced) left_pend <= len_ok & (chan == LR_LEFT);
      if (slot_good & (chan == LR_LEFT)) left_hold <= word;
      if (frame_done & (~bus.frame_valid | bus.frame_ready)) begin
        bus.left_data <= fmt(left_hold);
        bus.right_data <= fmt(word);
        bus.frame_valid <= 1'b1;
      end else if (frame_done) begin
        bus.overrun <= 1'b1;
      end else if (bus.frame_ready) begin
        bus.frame_valid <= 1'b0;
      end
    end
  end
endmodule
